// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: state codes,
// opcodes, IR field positions and the registered strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T1W   = 4'd3;
    localparam logic [3:0] S_T2    = 4'd4;
    localparam logic [3:0] S_T3    = 4'd5;
    localparam logic [3:0] S_T4    = 4'd6;
    localparam logic [3:0] S_T5    = 4'd7;
    localparam logic [3:0] S_HALT  = 4'd8;
    localparam logic [3:0] S_FAULT = 4'd9;
    localparam logic [3:0] S_PAUSE = 4'd10;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic sel_a;
        logic sel_b;
        logic sel_c;
        logic alu;
        logic busy;
        logic halted;
        logic fault;
    } ctrl_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
                          OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-to-N one-hot register select decoder with enable.
module reg_sel_decode #(
    parameter int NUM_REGS = 16
) (
    input  logic                en,
    input  logic [3:0]          sel,
    output logic [NUM_REGS-1:0] onehot
);

    assign onehot = en ? (NUM_REGS'(1) << sel) : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch / R-type execute sequencer for the Phase-1 datapath.
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                MARin,
    output logic                incPC,
    output logic                Zin,
    output logic                ZLowOut,
    output logic                PCin,
    output logic                read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [OPC_W-1:0]    opcode,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    logic [3:0] state_q;
    logic [3:0] nxt;
    logic [3:0] done_st;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = ir[OPC_MSB:OPC_LSB];
    assign unused_ir = ^ir[RC_LSB-1:0];

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    assign step_rise = step & ~step_q;
    assign done_st   = S_PAUSE;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) step_q <= 1'b0;
        else        step_q <= step;
    end
`else
    assign done_st = run ? S_T0 : S_IDLE;
`endif

    always_comb begin
        nxt = state_q;
        unique case (state_q)
            S_IDLE:  if (run) nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = mem_ready ? S_T2 : S_T1W;
            S_T1W: begin
                if (mem_ready)
                    nxt = S_T2;
                else if (cnt_q == 4'(WAIT_MAX - 1))
                    nxt = S_FAULT;
            end
            S_T2: begin
                if (is_rtype(op))       nxt = S_T3;
                else if (op == OP_NOP)  nxt = done_st;
                else if (op == OP_HALT) nxt = S_HALT;
                else                    nxt = S_FAULT;
            end
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = done_st;
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
`ifdef SINGLE_STEP_EN
            S_PAUSE: if (step_rise) nxt = S_T0;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        unique case (nxt)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            S_T1, S_T1W: begin
                ctrl_d.read   = 1'b1;
                ctrl_d.mdr_in = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
                ctrl_d.busy    = 1'b1;
            end
            S_T3: begin
                ctrl_d.sel_b = 1'b1;
                ctrl_d.y_in  = 1'b1;
                ctrl_d.busy  = 1'b1;
            end
            S_T4: begin
                ctrl_d.sel_c = 1'b1;
                ctrl_d.z_in  = 1'b1;
                ctrl_d.alu   = 1'b1;
                ctrl_d.busy  = 1'b1;
            end
            S_T5: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.sel_a    = 1'b1;
                ctrl_d.alu      = 1'b1;
                ctrl_d.busy     = 1'b1;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            S_FAULT: ctrl_d.fault  = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // the wait counter only runs while a fetch is stalled
    assign cnt_d = (state_q == S_T1W && !mem_ready) ? cnt_q + 4'd1 : 4'd0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= nxt;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    // memory-ready completion strobes cannot be known a cycle early
    assign PCin    = ctrl_q.read & mem_ready;
    assign ZLowOut = ctrl_q.zlow_out | PCin;

    assign PCout  = ctrl_q.pc_out;
    assign MARin  = ctrl_q.mar_in;
    assign incPC  = ctrl_q.inc_pc;
    assign Zin    = ctrl_q.z_in;
    assign read   = ctrl_q.read;
    assign MDRin  = ctrl_q.mdr_in;
    assign MDRout = ctrl_q.mdr_out;
    assign IRin   = ctrl_q.ir_in;
    assign Yin    = ctrl_q.y_in;
    assign busy   = ctrl_q.busy;
    assign halted = ctrl_q.halted;
    assign fault  = ctrl_q.fault;
    assign opcode = ctrl_q.alu ? OPC_W'(op) : '0;

    logic [3:0] out_sel;
    assign out_sel = ctrl_q.sel_b ? ir[RB_MSB:RB_LSB] : ir[RC_MSB:RC_LSB];

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_dec_in (
        .en     (ctrl_q.sel_a),
        .sel    (ir[RA_MSB:RA_LSB]),
        .onehot (reg_in)
    );

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_dec_out (
        .en     (ctrl_q.sel_b | ctrl_q.sel_c),
        .sel    (out_sel),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default build).
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic PCout, MARin, incPC, Zin, ZLowOut, PCin;
    logic read, MDRin, MDRout, IRin, Yin;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  opcode;
    logic busy, halted, fault;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .ir(ir), .PCout(PCout), .MARin(MARin), .incPC(incPC), .Zin(Zin),
        .ZLowOut(ZLowOut), .PCin(PCin), .read(read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .reg_in(reg_in),
        .reg_out(reg_out), .opcode(opcode), .busy(busy),
        .halted(halted), .fault(fault)
    );

    localparam logic [10:0] B_PCOUT = 11'h400;
    localparam logic [10:0] B_MARIN = 11'h200;
    localparam logic [10:0] B_INCPC = 11'h100;
    localparam logic [10:0] B_ZIN   = 11'h080;
    localparam logic [10:0] B_ZLOW  = 11'h040;
    localparam logic [10:0] B_PCIN  = 11'h020;
    localparam logic [10:0] B_READ  = 11'h010;
    localparam logic [10:0] B_MDRIN = 11'h008;
    localparam logic [10:0] B_MDROUT = 11'h004;
    localparam logic [10:0] B_IRIN  = 11'h002;
    localparam logic [10:0] B_YIN   = 11'h001;
    localparam logic [10:0] FETCH0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [31:0] IR_OR  = 32'h33A18000;

    typedef struct packed {
        logic [10:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  opc;
        logic        busy;
        logic        halted;
        logic        fault;
    } obs_t;

    typedef struct {
        logic        run;
        logic        rdy;
        logic [31:0] ir;
        obs_t        e;
        string       tag;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t plan[$];
    vec_t tbl[8];
    logic [4:0] rops[9] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                            5'd8, 5'd9, 5'd10, 5'd11};

    function automatic obs_t ob(input logic [10:0] s,
                                input logic [15:0] rin = '0,
                                input logic [15:0] rout = '0,
                                input logic [4:0]  opc = '0,
                                input logic b = 1'b1,
                                input logic h = 1'b0,
                                input logic f = 1'b0);
        obs_t o;
        o.s = s; o.rin = rin; o.rout = rout; o.opc = opc;
        o.busy = b; o.halted = h; o.fault = f;
        return o;
    endfunction

    function automatic obs_t idle_o();
        return ob(11'h0, '0, '0, '0, 1'b0);
    endfunction

    function automatic vec_t mk(input logic r, input logic m,
                                input logic [31:0] iv, input obs_t e,
                                input string tag);
        vec_t v;
        v.run = r; v.rdy = m; v.ir = iv; v.e = e; v.tag = tag;
        return v;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = {PCout, MARin, incPC, Zin, ZLowOut, PCin, read, MDRin,
               MDRout, IRin, Yin, reg_in, reg_out, opcode,
               busy, halted, fault};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
        checks++;
        if (!$onehot0(reg_out) ||
            $countones({PCout, MDRout, ZLowOut, |reg_out}) > 1) begin
            failures++;
            $display("FAIL %s bus_excl reg_out=%h pc=%b mdr=%b zl=%b",
                     tag, reg_out, PCout, MDRout, ZLowOut);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clock);
        #1;
        run = v.run;
        mem_ready = v.rdy;
        ir = v.ir;
        #3 check(v.tag, v.e);
    endtask

    task automatic run_plan();
        while (plan.size() > 0) apply(plan.pop_front());
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        clear = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        #1 check("reset", idle_o());
        @(posedge clock);
        #1 clear = 1'b1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // expected cycle trace of one instruction from the phase rules
    task automatic build(input logic [31:0] iv, input int d,
                         input logic run_end, input bit from_idle);
        logic [4:0]  op;
        logic [15:0] ha, hb, hc;
        op = iv[31:27];
        ha = 16'd1 << iv[26:23];
        hb = 16'd1 << iv[22:19];
        hc = 16'd1 << iv[18:15];
        if (from_idle) plan.push_back(mk(1'b1, rb(), iv, idle_o(), "idle"));
        plan.push_back(mk(rb(), rb(), iv, ob(FETCH0), "t0"));
        for (int k = 0; k < d; k++)
            plan.push_back(mk(rb(), 1'b0, iv, ob(B_READ | B_MDRIN), "wait"));
        plan.push_back(mk(rb(), 1'b1, iv,
                          ob(B_READ | B_MDRIN | B_ZLOW | B_PCIN), "fetch"));
        if (op inside {[5'd3:5'd11]}) begin
            plan.push_back(mk(rb(), rb(), iv, ob(B_MDROUT | B_IRIN), "t2"));
            plan.push_back(mk(rb(), rb(), iv, ob(B_YIN, '0, hb), "t3"));
            plan.push_back(mk(rb(), rb(), iv, ob(B_ZIN, '0, hc, op), "t4"));
            plan.push_back(mk(run_end, rb(), iv, ob(B_ZLOW, ha, '0, op), "t5"));
        end else begin
            plan.push_back(mk(run_end, rb(), iv,
                              ob(B_MDROUT | B_IRIN), "t2nop"));
        end
    endtask

    task automatic prefix_to_t2(input logic [31:0] iv);
        plan.push_back(mk(1'b1, 1'b0, iv, idle_o(), "idle"));
        plan.push_back(mk(1'b1, 1'b0, iv, ob(FETCH0), "t0"));
        plan.push_back(mk(1'b1, 1'b1, iv,
                          ob(B_READ | B_MDRIN | B_ZLOW | B_PCIN), "fetch"));
        plan.push_back(mk(1'b1, 1'b0, iv, ob(B_MDROUT | B_IRIN), "t2"));
    endtask

    initial begin
        #2 check("reset_init", idle_o());
        @(posedge clock);
        #1 clear = 1'b1;

        tbl[0] = mk(1, 1, IR_OR, idle_o(), "or_idle");
        tbl[1] = mk(1, 1, IR_OR, ob(FETCH0), "or_t0");
        tbl[2] = mk(1, 1, IR_OR, ob(B_READ | B_MDRIN | B_ZLOW | B_PCIN), "or_t1");
        tbl[3] = mk(1, 1, IR_OR, ob(B_MDROUT | B_IRIN), "or_t2");
        tbl[4] = mk(1, 1, IR_OR, ob(B_YIN, '0, 16'h0010), "or_t3");
        tbl[5] = mk(1, 1, IR_OR, ob(B_ZIN, '0, 16'h0008, 5'b00110), "or_t4");
        tbl[6] = mk(0, 1, IR_OR, ob(B_ZLOW, 16'h0080, '0, 5'b00110), "or_t5");
        tbl[7] = mk(0, 1, IR_OR, idle_o(), "or_done");
        for (int i = 0; i < 8; i++) apply(tbl[i]);

        build(IR_OR, 3, 1'b0, 1'b1);
        plan.push_back(mk(1'b0, 1'b0, IR_OR, idle_o(), "delay_done"));
        run_plan();

        build(IR_OR, 0, 1'b0, 1'b1);
        foreach (plan[i]) begin
            plan[i].run = (plan[i].tag == "t3" || plan[i].tag == "t4" ||
                           plan[i].tag == "t5") ? 1'b0 : 1'b1;
        end
        plan.push_back(mk(1'b0, 1'b1, IR_OR, idle_o(), "drop_idle"));
        run_plan();

        build(IR_OR, 0, 1'b1, 1'b1);
        void'(plan.pop_back());
        run_plan();
        #1 clear = 1'b0;
        #1 check("clr_async", idle_o());
        @(posedge clock);
        #1;
        clear = 1'b1;
        run = 1'b0;
        build(IR_OR, 0, 1'b0, 1'b1);
        run_plan();

        plan.push_back(mk(1'b1, 1'b0, IR_OR, idle_o(), "idle"));
        plan.push_back(mk(1'b1, 1'b0, IR_OR, ob(FETCH0), "t0"));
        for (int k = 0; k < 16; k++)
            plan.push_back(mk(1'b1, 1'b0, IR_OR, ob(B_READ | B_MDRIN), "tmo_wait"));
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(rb(), rb(), IR_OR,
                              ob(11'h0, '0, '0, '0, 1'b0, 1'b0, 1'b1), "tmo_fault"));
        run_plan();
        do_reset();

        prefix_to_t2(32'hD8000000);
        for (int k = 0; k < 4; k++)
            plan.push_back(mk(1'(k & 1), rb(), 32'hD8000000,
                              ob(11'h0, '0, '0, '0, 1'b0, 1'b1, 1'b0), "halt"));
        run_plan();
        do_reset();

        prefix_to_t2(32'hF8000000);
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(rb(), rb(), 32'hF8000000,
                              ob(11'h0, '0, '0, '0, 1'b0, 1'b0, 1'b1), "illegal"));
        run_plan();
        do_reset();

        begin
            bit idle = 1'b1;
            for (int n = 0; n < 40; n++) begin
                logic [31:0] iv;
                logic        re;
                iv[31:27] = ($urandom_range(0, 9) < 8) ?
                            rops[$urandom_range(0, 8)] : 5'b11010;
                iv[26:0] = 27'($urandom);
                re = rb();
                build(iv, $urandom_range(0, 4), re, idle);
                idle = !re;
            end
            run_plan();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
